// File: rtl/seq_mult_16b.sv
// -----------------------------------------------------------------------------
// seq_mult_16b
//   Unsigned 16x16 sequential shift-add multiplier. One add-and-shift
//   iteration per clock, 16 iterations per operation, 32-bit result {A,Q}.
//   The running partial sum A and the multiplicand M feed a single RCA_16b
//   ripple-carry adder each cycle.
//
//   Ports:
//     clk      in   1   rising-edge clock
//     rst_n    in   1   asynchronous active-low reset
//     start    in   1   operation request, honoured in IDLE or DONE only
//     mcand    in  16   multiplicand, captured on an accepted start
//     mplier   in  16   multiplier, captured on an accepted start
//     busy     out  1   high while iterating (RUN)
//     done     out  1   one-cycle pulse when product is final
//     product  out 32   {A,Q}; final from DONE until the next accepted start
// -----------------------------------------------------------------------------
module seq_mult_16b (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] mcand,
    input  logic [15:0] mplier,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] m_q, m_d;
    logic [15:0] a_q, a_d;
    logic [15:0] q_q, q_d;
    logic        c_q, c_d;
    logic [4:0]  cnt_q, cnt_d;

    logic [15:0] sum_w;
    logic        c_out_w;
    logic [16:0] ca_w;

    RCA_16b u_rca (
        .a     (a_q),
        .b     (m_q),
        .c_in  (1'b0),
        .sum   (sum_w),
        .c_out (c_out_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        ca_w    = {c_q, a_q};

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    m_d     = mcand;
                    q_d     = mplier;
                    a_d     = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Add (or pass) and shift folded into a single update:
                // {C,A} is formed first, then {C,A,Q} shifts right by one,
                // so the adder carry lands in A[15] and C always clears.
                ca_w  = q_q[0] ? {c_out_w, sum_w} : {1'b0, a_q};
                c_d   = 1'b0;
                a_d   = ca_w[16:1];
                q_d   = {ca_w[0], q_q[15:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = {a_q, q_q};

endmodule

// -----------------------------------------------------------------------------
// RCA_16b
//   16-bit ripple-carry adder.
//   Ports: a, b (16-bit addends), c_in (carry in), sum (16-bit), c_out.
// -----------------------------------------------------------------------------
module RCA_16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);

    logic carry;

    always_comb begin
        sum   = '0;
        carry = c_in;
        for (int unsigned i = 0; i < 16; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        c_out = carry;
    end

endmodule

// File: tb/tb_seq_mult_16b.sv
module tb_seq_mult_16b;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int checks   = 0;
    int failures = 0;

    seq_mult_16b dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive start for one edge; check busy rises on the accepting edge.
    // Afterwards the operand inputs are scrambled: they must not matter.
    task automatic start_op(input logic [15:0] mc, input logic [15:0] mp, input string tag);
        @(negedge clk);
        start  = 1'b1;
        mcand  = mc;
        mplier = mp;
        @(posedge clk);
        #1;
        chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        start  = 1'b0;
        mcand  = 16'($urandom);
        mplier = 16'($urandom);
    endtask

    // Count edges until done, bounded; check latency, product and busy.
    task automatic wait_done(input int exp_cycles, input logic [31:0] exp_prod, input string tag);
        int cycles = 0;
        while (done !== 1'b1 && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        chk({tag, "_latency"}, 32'(cycles), 32'(exp_cycles));
        chk({tag, "_product"}, product, exp_prod);
        chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int done_seen;

        rst_n  = 1'b0;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        #12;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_product", product, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic 3 x 5 and hold afterwards
        start_op(16'd3, 16'd5, "basic");
        wait_done(16, 32'h0000_000F, "basic");
        @(posedge clk);
        #1;
        chk("basic_done_falls", {31'd0, done}, 32'd0);
        chk("basic_hold1", product, 32'h0000_000F);
        repeat (3) @(posedge clk);
        #1;
        chk("basic_hold2", product, 32'h0000_000F);

        // Carry retention
        start_op(16'hFFFF, 16'hFFFF, "ffff");
        wait_done(16, 32'hFFFE_0001, "ffff");
        start_op(16'h8000, 16'h0002, "msb");
        wait_done(16, 32'h0001_0000, "msb");

        // Zero operands: no early termination
        start_op(16'h0000, 16'h1234, "zero_a");
        wait_done(16, 32'h0000_0000, "zero_a");
        start_op(16'h0FED, 16'h0FED, "nz");
        wait_done(16, 32'h00FD_A169, "nz");
        start_op(16'h1234, 16'h0000, "zero_b");
        wait_done(16, 32'h0000_0000, "zero_b");

        // Start pulsed during RUN is ignored
        start_op(16'h0010, 16'h0010, "ign");
        repeat (4) @(posedge clk);
        @(negedge clk);
        start  = 1'b1;
        mcand  = 16'hFFFF;
        mplier = 16'hFFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ign_busy_mid", {31'd0, busy}, 32'd1);
        wait_done(11, 32'h0000_0100, "ign");
        @(posedge clk);
        #1;
        chk("ign_single_done", {31'd0, done}, 32'd0);
        chk("ign_no_restart", {31'd0, busy}, 32'd0);

        // Back-to-back: start held during DONE
        start_op(16'h00FF, 16'h0101, "b2b1");
        wait_done(16, 32'h0000_FFFF, "b2b1");
        start  = 1'b1;
        mcand  = 16'd7;
        mplier = 16'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy_rerise", {31'd0, busy}, 32'd1);
        chk("b2b_done_falls", {31'd0, done}, 32'd0);
        wait_done(16, 32'h0000_003F, "b2b2");

        // Asynchronous reset mid-operation
        start_op(16'h1234, 16'h5678, "rst");
        repeat (8) @(posedge clk);
        #3;
        chk("rst_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy_async", {31'd0, busy}, 32'd0);
        chk("rst_done_async", {31'd0, done}, 32'd0);
        chk("rst_product_async", product, 32'd0);
        #2;
        rst_n = 1'b1;
        done_seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        chk("rst_no_done_after", 32'(done_seen), 32'd0);
        start_op(16'h1234, 16'h5678, "post_rst");
        wait_done(16, 32'h0626_0060, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
